// File: rtl/ldr_str_unit_if.sv
// Request, memory-file and writeback-response bundle of the LDR/STR memory-access stage.
// The slave modport is the unit's view; master is the surrounding pipeline/memory view.
interface ldr_str_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic              req_up;
    logic              req_pre;
    logic              req_wb;
    logic [DATA_W-1:0] req_base;
    logic [11:0]       req_offset;
    logic [3:0]        req_rd;
    logic [3:0]        req_rn;
    logic [DATA_W-1:0] req_store_data;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_ldr_str_en;
    logic              mem_load_en;
    logic              mem_store_en;
    logic [DATA_W-1:0] mem_read_data;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_rd_we;
    logic [3:0]        resp_rd;
    logic [DATA_W-1:0] resp_rd_data;
    logic              resp_rn_we;
    logic [3:0]        resp_rn;
    logic [DATA_W-1:0] resp_rn_data;
    logic              resp_fault;

    modport slave (
        input  req_valid, req_load, req_up, req_pre, req_wb, req_base, req_offset,
               req_rd, req_rn, req_store_data, mem_read_data, resp_ready,
        output req_ready, mem_addr, mem_write_data, mem_ldr_str_en, mem_load_en,
               mem_store_en, resp_valid, resp_rd_we, resp_rd, resp_rd_data,
               resp_rn_we, resp_rn, resp_rn_data, resp_fault
    );

    modport master (
        output req_valid, req_load, req_up, req_pre, req_wb, req_base, req_offset,
               req_rd, req_rn, req_store_data, mem_read_data, resp_ready,
        input  req_ready, mem_addr, mem_write_data, mem_ldr_str_en, mem_load_en,
               mem_store_en, resp_valid, resp_rd_we, resp_rd, resp_rd_data,
               resp_rn_we, resp_rn, resp_rn_data, resp_fault
    );
endinterface

// File: rtl/ldr_str_unit.sv
// LDR/STR memory-access stage: effective address, single-cycle memory enable pulse, writeback response.
// Macro LDR_STR_BASE_WB_EN enables the Rn base-writeback response; undefined ties resp_rn_we low.
module ldr_str_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           rst,
    ldr_str_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_r, state_nx;

    logic              load_r, up_r, pre_r;
    logic [DATA_W-1:0] base_r;
    logic [11:0]       offset_r;
    logic [3:0]        rd_r, rn_r;
    logic [DATA_W-1:0] store_data_r;

    logic [DATA_W-1:0] upd_s, ea_s;
    logic              fault_s, rn_we_s;

    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_write_data_r;
    logic              en_r, load_en_r, store_en_r;
    logic              req_ready_r, resp_valid_r;
    logic              fault_r, rd_we_r, rn_we_r;
    logic [DATA_W-1:0] rd_data_r, upd_r;

`ifdef LDR_STR_BASE_WB_EN
    logic wb_r;
`else
    logic unused_wb_s;
    assign unused_wb_s = bus.req_wb;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:    if (bus.req_valid) state_nx = ADDR;   else state_nx = IDLE;
            ADDR:    if (fault_s)       state_nx = RESP;   else state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    if (bus.resp_ready) state_nx = IDLE;  else state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Effective address, fault detection and base-writeback qualification
    always_comb begin
        upd_s   = '0;
        ea_s    = '0;
        fault_s = 1'b0;
        rn_we_s = 1'b0;
        if (up_r) begin
            upd_s = base_r + {{(DATA_W-12){1'b0}}, offset_r};
        end else begin
            upd_s = base_r - {{(DATA_W-12){1'b0}}, offset_r};
        end
        if (pre_r) begin
            ea_s = upd_s;
        end else begin
            ea_s = base_r;
        end
        fault_s = (ea_s[1:0] != 2'b00) || (ea_s[DATA_W-1:ADDR_W+2] != '0);
`ifdef LDR_STR_BASE_WB_EN
        // A load into the base register itself keeps the loaded value
        rn_we_s = !fault_s && (!pre_r || wb_r) && !(load_r && (rd_r == rn_r));
`else
        rn_we_s = 1'b0;
`endif
    end

    // Request capture and response/memory datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_r           <= 1'b0;
            up_r             <= 1'b0;
            pre_r            <= 1'b0;
            base_r           <= '0;
            offset_r         <= 12'd0;
            rd_r             <= 4'd0;
            rn_r             <= 4'd0;
            store_data_r     <= '0;
            mem_addr_r       <= '0;
            mem_write_data_r <= '0;
            fault_r          <= 1'b0;
            rd_we_r          <= 1'b0;
            rn_we_r          <= 1'b0;
            rd_data_r        <= '0;
            upd_r            <= '0;
`ifdef LDR_STR_BASE_WB_EN
            wb_r             <= 1'b0;
`endif
        end else begin
            if ((state_r == IDLE) && bus.req_valid) begin
                load_r       <= bus.req_load;
                up_r         <= bus.req_up;
                pre_r        <= bus.req_pre;
                base_r       <= bus.req_base;
                offset_r     <= bus.req_offset;
                rd_r         <= bus.req_rd;
                rn_r         <= bus.req_rn;
                store_data_r <= bus.req_store_data;
`ifdef LDR_STR_BASE_WB_EN
                wb_r         <= bus.req_wb;
`endif
            end
            // Address/data move only here, while every enable is still low
            if (state_r == ADDR) begin
                mem_addr_r       <= ea_s[ADDR_W+1:2];
                mem_write_data_r <= store_data_r;
                fault_r          <= fault_s;
                rd_we_r          <= load_r && !fault_s;
                rn_we_r          <= rn_we_s;
                upd_r            <= upd_s;
                rd_data_r        <= '0;
            end
            if ((state_r == ACCESS) && load_r) begin
                rd_data_r <= bus.mem_read_data;
            end
        end
    end

    // Handshake flags and memory enables registered from the next state so they never glitch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            en_r         <= 1'b0;
            load_en_r    <= 1'b0;
            store_en_r   <= 1'b0;
        end else begin
            req_ready_r  <= (state_nx == IDLE);
            resp_valid_r <= (state_nx == RESP);
            en_r         <= (state_nx == ACCESS);
            load_en_r    <= (state_nx == ACCESS) && load_r;
            store_en_r   <= (state_nx == ACCESS) && !load_r;
        end
    end

    assign bus.req_ready      = req_ready_r;
    assign bus.mem_addr       = mem_addr_r;
    assign bus.mem_write_data = mem_write_data_r;
    assign bus.mem_ldr_str_en = en_r;
    assign bus.mem_load_en    = load_en_r;
    assign bus.mem_store_en   = store_en_r;
    assign bus.resp_valid     = resp_valid_r;
    assign bus.resp_rd_we     = rd_we_r;
    assign bus.resp_rd        = rd_r;
    assign bus.resp_rd_data   = rd_data_r;
    assign bus.resp_rn_we     = rn_we_r;
    assign bus.resp_rn        = rn_r;
    assign bus.resp_rn_data   = upd_r;
    assign bus.resp_fault     = fault_r;
endmodule

// File: tb/tb_ldr_str_unit.sv
// Self-checking bench for ldr_str_unit: vector table with a response scoreboard, plus reset sequences.
module tb_ldr_str_unit;
    localparam bit WB_EN =
`ifdef LDR_STR_BASE_WB_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        logic        load;
        logic        up;
        logic        pre;
        logic        wb;
        logic [31:0] base;
        logic [11:0] offset;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [31:0] sdata;
        logic        fault;
        logic [3:0]  addr;
        logic        rd_we;
        logic [31:0] rd_data;
        logic        rn_we_wb;   // expected resp_rn_we when base writeback is built in
        logic [31:0] rn_data;
        int          hold;       // cycles resp_ready stays low in RESP
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb_q[$];
    vec_t vecs[10];
    logic [31:0] mem [16];

    ldr_str_unit_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    ldr_str_unit #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural 16-word memory file: combinational read, write on enabled edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | i;
        end else if (bus.mem_ldr_str_en && bus.mem_store_en) begin
            mem[bus.mem_addr] <= bus.mem_write_data;
        end
    end
    assign bus.mem_read_data = mem[bus.mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: compare each accepted response against the oldest outstanding request
    always @(negedge clk) begin
        if (rst && bus.resp_valid && bus.resp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                chk("resp_fault", {31'd0, bus.resp_fault}, {31'd0, e.fault});
                chk("resp_rd_we", {31'd0, bus.resp_rd_we}, {31'd0, e.rd_we});
                chk("resp_rd", {28'd0, bus.resp_rd}, {28'd0, e.rd});
                if (e.rd_we) chk("resp_rd_data", bus.resp_rd_data, e.rd_data);
                chk("resp_rn_we", {31'd0, bus.resp_rn_we}, {31'd0, e.rn_we_wb & WB_EN});
                chk("resp_rn", {28'd0, bus.resp_rn}, {28'd0, e.rn});
                chk("resp_rn_data", bus.resp_rn_data, e.rn_data);
            end
        end
    end

    task automatic drive_req(input vec_t v);
        bus.req_load       = v.load;
        bus.req_up         = v.up;
        bus.req_pre        = v.pre;
        bus.req_wb         = v.wb;
        bus.req_base       = v.base;
        bus.req_offset     = v.offset;
        bus.req_rd         = v.rd;
        bus.req_rn         = v.rn;
        bus.req_store_data = v.sdata;
        bus.req_valid      = 1'b1;
    endtask

    task automatic run(input vec_t v);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        drive_req(v);
        bus.resp_ready = (v.hold == 0);
        sb_q.push_back(v);
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = bus.req_ready;
        end
        if (!got) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            void'(sb_q.pop_back());
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);   // cycle 1: ADDR
        chk("c1_en", {31'd0, bus.mem_ldr_str_en}, 32'd0);
        chk("c1_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("c1_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);   // cycle 2: ACCESS or faulting RESP
        if (v.fault) begin
            chk("c2_fault_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("c2_fault_en", {29'd0, bus.mem_ldr_str_en, bus.mem_load_en, bus.mem_store_en}, 32'd0);
        end else begin
            chk("c2_en", {29'd0, bus.mem_ldr_str_en, bus.mem_load_en, bus.mem_store_en},
                {29'd0, 1'b1, v.load, !v.load});
            chk("c2_addr", {28'd0, bus.mem_addr}, {28'd0, v.addr});
            if (!v.load) chk("c2_wdata", bus.mem_write_data, v.sdata);
            chk("c2_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
            @(negedge clk);   // cycle 3: RESP
            chk("c3_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("c3_en", {29'd0, bus.mem_ldr_str_en, bus.mem_load_en, bus.mem_store_en}, 32'd0);
        end
        if (v.hold > 0) begin
            for (int h = 0; h < v.hold; h++) begin
                if (h > 0) @(negedge clk);
                chk("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
                chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
                chk("bp_rn_data", bus.resp_rn_data, v.rn_data);
                chk("bp_fault", {31'd0, bus.resp_fault}, {31'd0, v.fault});
                if (v.rd_we) chk("bp_rd_data", bus.resp_rd_data, v.rd_data);
            end
            @(posedge clk); #1;
            bus.resp_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("idle_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           ld    up    pre   wb    base          off      rd     rn     sdata          flt   addr   rdwe  rd_data        rnwe  rn_data        hold
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 12'd4,  4'd1,  4'd0,  32'hDEAD_BEEF, 1'b0, 4'd3,  1'b0, 32'h0,         1'b0, 32'h0000_000C, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 12'd4,  4'd3,  4'd0,  32'h0,         1'b0, 4'd3,  1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_000C, 0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 12'd8,  4'd4,  4'd5,  32'h0,         1'b0, 4'd4,  1'b1, 32'hA5A5_0004, 1'b1, 32'h0000_0008, 5};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0006, 12'd0,  4'd1,  4'd2,  32'h0,         1'b1, 4'd0,  1'b0, 32'h0,         1'b0, 32'h0000_0006, 0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 12'd0,  4'd1,  4'd2,  32'h0,         1'b1, 4'd0,  1'b0, 32'h0,         1'b0, 32'h0000_0040, 0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 12'd12, 4'd2,  4'd2,  32'h0,         1'b0, 4'd11, 1'b1, 32'hA5A5_000B, 1'b0, 32'h0000_002C, 0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_003C, 12'd60, 4'd6,  4'd9,  32'h1234_5678, 1'b0, 4'd0,  1'b0, 32'h0,         1'b1, 32'h0000_0000, 0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 12'd0,  4'd7,  4'd8,  32'h0,         1'b0, 4'd0,  1'b1, 32'h1234_5678, 1'b0, 32'h0000_0000, 0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 12'd8,  4'd1,  4'd3,  32'h0,         1'b1, 4'd0,  1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC, 0};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_003C, 12'd0,  4'd10, 4'd11, 32'h0,         1'b0, 4'd15, 1'b1, 32'hA5A5_000F, 1'b1, 32'h0000_003C, 0};

        bus.req_valid = 1'b0;
        drive_req(vecs[0]);
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_en", {29'd0, bus.mem_ldr_str_en, bus.mem_load_en, bus.mem_store_en}, 32'd0);
        chk("rst_mem_addr", {28'd0, bus.mem_addr}, 32'd0);
        chk("rst_resp_flags", {29'd0, bus.resp_rd_we, bus.resp_rn_we, bus.resp_fault}, 32'd0);
        chk("rst_rn_data", bus.resp_rn_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) run(vecs[i]);

        // Asynchronous reset while the enable pulse is high
        @(posedge clk); #1;
        drive_req(vecs[6]);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;   // handshake edge passed
        bus.req_valid = 1'b0;
        @(posedge clk); #1;   // ADDR -> ACCESS edge passed
        chk("ra_en_before", {31'd0, bus.mem_ldr_str_en}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ra_en_after", {29'd0, bus.mem_ldr_str_en, bus.mem_load_en, bus.mem_store_en}, 32'd0);
        chk("ra_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("ra_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        end
        chk("ra_idle_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
